// File: rtl/frame_word_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_word_scheduler
// Description : Telemetry word scheduler. At each word boundary it picks the
//               next 16-bit word source (frame sync 1, frame sync 2, subframe
//               ID, payload data or fill), loads it into a shift register and
//               serialises it MSB-first. Drains a first-word-fall-through
//               payload FIFO and maintains the subframe counter.
//
// Ports       : clock_in     - single clock, rising edge
//               reset_n      - asynchronous active-low reset
//               enable       - run request, sampled on frame sync 1 strobes
//               word_strobe  - one-cycle pulse at each word boundary
//               slot_f1/f2/sf/d - slot type of the word loaded on the strobe
//               sf_max       - subframe counter terminal value
//               data_in      - FIFO head word (FWFT)
//               data_valid   - FIFO not empty
//               data_ready   - FIFO pop (combinational)
//               serial_out   - serial bitstream, MSB first
//               frame_start  - one-cycle pulse after each SYNC1 load
//               running      - scheduler is in the RUN state
//               slot_error   - sticky slot-flag error
//               underrun_ct  - saturating payload underrun count
//
// Revision    : 1.0 - initial release
// ============================================================================
module frame_word_scheduler (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        word_strobe,
  input  logic        slot_f1,
  input  logic        slot_f2,
  input  logic        slot_sf,
  input  logic        slot_d,
  input  logic [15:0] sf_max,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        serial_out,
  output logic        frame_start,
  output logic        running,
  output logic        slot_error,
  output logic [15:0] underrun_ct
);

  localparam logic [15:0] c_SYNC1     = 16'hFE6B;
  localparam logic [15:0] c_SYNC2     = 16'h2840;
  localparam logic [15:0] c_FILL_WORD = 16'hAAAA;
  localparam logic [15:0] c_CT_MAX    = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_shift;
  logic [15:0] r_sf_count;
  logic [15:0] r_underrun_ct;
  logic        r_frame_start;
  logic        r_slot_error;

  // Priority-resolved slot flags: f1 > f2 > sf > d
  logic        w_sel_f1;
  logic        w_sel_f2;
  logic        w_sel_sf;
  logic        w_sel_d;
  logic [2:0]  w_flag_cnt;
  logic        w_multi_flag;

  logic [15:0] w_load_word;
  logic        w_load_sync1;
  logic        w_sf_step;
  logic        w_underrun;
  logic        w_pop;
  logic        w_set_error;

  assign w_sel_f1     = slot_f1;
  assign w_sel_f2     = ~slot_f1 & slot_f2;
  assign w_sel_sf     = ~slot_f1 & ~slot_f2 & slot_sf;
  assign w_sel_d      = ~slot_f1 & ~slot_f2 & ~slot_sf & slot_d;
  assign w_flag_cnt   = {2'b00, slot_f1} + {2'b00, slot_f2}
                      + {2'b00, slot_sf} + {2'b00, slot_d};
  assign w_multi_flag = (w_flag_cnt > 3'd1);

  // --------------------------------------------------------------------------
  // Next-state and word-source selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load_word  = c_FILL_WORD;
    w_load_sync1 = 1'b0;
    w_sf_step    = 1'b0;
    w_underrun   = 1'b0;
    w_pop        = 1'b0;
    w_set_error  = 1'b0;

    if (word_strobe) begin
      // Conflicting flags are flagged in any state; the winner still applies.
      if (w_multi_flag) begin
        w_set_error = 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // The entering strobe does not advance the subframe counter, so
          // the first frame carries the current count.
          if (w_sel_f1 && enable) begin
            w_state_next = ST_RUN;
            w_load_word  = c_SYNC1;
            w_load_sync1 = 1'b1;
          end
        end

        ST_RUN: begin
          if (w_sel_f1) begin
            if (enable) begin
              w_load_word  = c_SYNC1;
              w_load_sync1 = 1'b1;
              w_sf_step    = 1'b1;
            end else begin
              // Stop only at a frame boundary; this slot goes out as fill.
              w_state_next = ST_IDLE;
            end
          end else if (w_sel_f2) begin
            w_load_word = c_SYNC2;
          end else if (w_sel_sf) begin
            w_load_word = r_sf_count;
          end else if (w_sel_d) begin
            if (data_valid) begin
              w_load_word = data_in;
              w_pop       = 1'b1;
            end else begin
              w_underrun  = 1'b1;
            end
          end else begin
            w_set_error = 1'b1;
          end
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_shift       <= 16'h0000;
      r_sf_count    <= 16'h0000;
      r_underrun_ct <= 16'h0000;
      r_frame_start <= 1'b0;
      r_slot_error  <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // A strobe always reloads, discarding any bits not yet shifted out.
      if (word_strobe) begin
        r_shift <= w_load_word;
      end else begin
        r_shift <= {r_shift[14:0], 1'b0};
      end

      if (w_sf_step) begin
        if (r_sf_count >= sf_max) begin
          r_sf_count <= 16'h0000;
        end else begin
          r_sf_count <= r_sf_count + 16'h0001;
        end
      end

      if (w_underrun && (r_underrun_ct != c_CT_MAX)) begin
        r_underrun_ct <= r_underrun_ct + 16'h0001;
      end

      r_frame_start <= w_load_sync1;

      if (w_set_error) begin
        r_slot_error <= 1'b1;
      end
    end
  end

  assign data_ready  = w_pop;
  assign serial_out  = r_shift[15];
  assign frame_start = r_frame_start;
  assign running     = (r_state == ST_RUN);
  assign slot_error  = r_slot_error;
  assign underrun_ct = r_underrun_ct;

endmodule
`default_nettype wire

// File: tb/tb_frame_word_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_word_scheduler
// Description : Self-checking bench for frame_word_scheduler. Words are driven
//               from a vector table and hand sequences; the expected word is
//               queued at the strobe and compared against the bits collected
//               from serial_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_word_scheduler;

  logic        clock_in;
  logic        reset_n;
  logic        enable;
  logic        word_strobe;
  logic        slot_f1;
  logic        slot_f2;
  logic        slot_sf;
  logic        slot_d;
  logic [15:0] sf_max;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        serial_out;
  logic        frame_start;
  logic        running;
  logic        slot_error;
  logic [15:0] underrun_ct;

  typedef struct packed {
    logic        f1;
    logic        f2;
    logic        sf;
    logic        d;
    logic [15:0] data;
    logic        valid;
    logic        en;
    logic [15:0] exp_word;
    logic        exp_ready;
  } vec_t;

  int          errors;
  int          checks;
  int          pop_count;
  int          fs_count;
  logic [15:0] sb_q[$];
  vec_t        vecs[10];
  logic [15:0] sf_exp[4];

  frame_word_scheduler dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .word_strobe (word_strobe),
    .slot_f1     (slot_f1),
    .slot_f2     (slot_f2),
    .slot_sf     (slot_sf),
    .slot_d      (slot_d),
    .sf_max      (sf_max),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .serial_out  (serial_out),
    .frame_start (frame_start),
    .running     (running),
    .slot_error  (slot_error),
    .underrun_ct (underrun_ct)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) begin
    if (data_ready)  pop_count <= pop_count + 1;
    if (frame_start) fs_count  <= fs_count + 1;
  end

  function automatic vec_t mk(input logic [3:0] flags, input logic [15:0] data,
                              input logic valid, input logic en,
                              input logic [15:0] exp_word, input logic exp_ready);
    vec_t v;
    v.f1 = flags[3]; v.f2 = flags[2]; v.sf = flags[1]; v.d = flags[0];
    v.data = data; v.valid = valid; v.en = en;
    v.exp_word = exp_word; v.exp_ready = exp_ready;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    word_strobe = 1'b0;
    slot_f1 = 1'b0; slot_f2 = 1'b0; slot_sf = 1'b0; slot_d = 1'b0;
    data_valid = 1'b0;
  endtask

  // Drive one strobe at the current negedge, then collect nbits serial bits
  // (one per clock); the next strobe may follow immediately.
  task automatic send(input vec_t v, input int nbits);
    logic [31:0] cap;
    logic [31:0] exp;
    logic [15:0] w;
    slot_f1 = v.f1; slot_f2 = v.f2; slot_sf = v.sf; slot_d = v.d;
    data_in = v.data; data_valid = v.valid; enable = v.en;
    word_strobe = 1'b1;
    sb_q.push_back(v.exp_word);
    #1;
    check("data_ready", {31'd0, data_ready}, {31'd0, v.exp_ready});
    @(posedge clock_in);
    @(negedge clock_in);
    idle_inputs();
    cap = 32'd0;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) begin
        @(posedge clock_in);
        @(negedge clock_in);
      end
      cap = {cap[30:0], serial_out};
    end
    w = sb_q.pop_front();
    if (nbits <= 16) exp = {16'd0, w} >> (16 - nbits);
    else             exp = {16'd0, w} << (nbits - 16);
    check("serial_word", cap, exp);
  endtask

  initial begin
    int base_pop;
    int base_fs;
    errors = 0; checks = 0; pop_count = 0; fs_count = 0;
    reset_n = 1'b0; enable = 1'b0; sf_max = 16'd3; data_in = 16'h0000;
    idle_inputs();

    // Idle-then-run table: enable raised mid-frame has no effect until f1.
    vecs[0] = mk(4'b1000, 16'h0000, 1'b0, 1'b0, 16'hAAAA, 1'b0);
    vecs[1] = mk(4'b0100, 16'h0000, 1'b0, 1'b0, 16'hAAAA, 1'b0);
    vecs[2] = mk(4'b0001, 16'h9999, 1'b1, 1'b0, 16'hAAAA, 1'b0);
    vecs[3] = mk(4'b0010, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b0);
    vecs[4] = mk(4'b1000, 16'h0000, 1'b0, 1'b1, 16'hFE6B, 1'b0);
    vecs[5] = mk(4'b0100, 16'h0000, 1'b0, 1'b1, 16'h2840, 1'b0);
    vecs[6] = mk(4'b0001, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b1);
    vecs[7] = mk(4'b0001, 16'h5678, 1'b1, 1'b1, 16'h5678, 1'b1);
    vecs[8] = mk(4'b0010, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
    vecs[9] = mk(4'b0001, 16'hBEEF, 1'b0, 1'b1, 16'hAAAA, 1'b0);
    sf_exp[0] = 16'd1; sf_exp[1] = 16'd2; sf_exp[2] = 16'd0; sf_exp[3] = 16'd1;

    // Reset state
    repeat (3) @(negedge clock_in);
    check("rst_serial_out",  {31'd0, serial_out},  32'd0);
    check("rst_data_ready",  {31'd0, data_ready},  32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_running",     {31'd0, running},     32'd0);
    check("rst_slot_error",  {31'd0, slot_error},  32'd0);
    check("rst_underrun_ct", {16'd0, underrun_ct}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock_in);

    // Table-driven words
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        check("running_before_f1", {31'd0, running}, 32'd0);
        base_pop = pop_count;
        base_fs  = fs_count;
      end
      send(vecs[i], 16);
      if (i == 4) check("running_after_f1", {31'd0, running}, 32'd1);
    end
    check("frame_start_pulses", fs_count - base_fs, 32'd1);
    check("pop_count_frame", pop_count - base_pop, 32'd2);
    check("underrun_first", {16'd0, underrun_ct}, 32'd1);
    check("no_slot_error", {31'd0, slot_error}, 32'd0);

    // Subframe wrap with sf_max = 2 (first frame above carried 0)
    sf_max = 16'd2;
    for (int i = 0; i < 4; i++) begin
      send(mk(4'b1000, 16'h0, 1'b0, 1'b1, 16'hFE6B, 1'b0), 16);
      send(mk(4'b0010, 16'h0, 1'b0, 1'b1, sf_exp[i], 1'b0), 16);
    end

    // Underrun saturation: back-to-back d strobes with an empty FIFO
    base_pop = pop_count;
    slot_d = 1'b1; data_valid = 1'b0; word_strobe = 1'b1; enable = 1'b1;
    for (int i = 0; i < 65533; i++) @(negedge clock_in);
    check("underrun_fffe", {16'd0, underrun_ct}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) @(negedge clock_in);
    check("underrun_sat", {16'd0, underrun_ct}, 32'h0000FFFF);
    idle_inputs();
    @(negedge clock_in);
    check("underrun_no_pop", pop_count - base_pop, 32'd0);

    // Drop enable mid-frame: frame completes, next f1 emits fill and stops
    send(mk(4'b0100, 16'h0, 1'b0, 1'b0, 16'h2840, 1'b0), 16);
    send(mk(4'b0010, 16'h0, 1'b0, 1'b0, 16'h0001, 1'b0), 16);
    check("running_still", {31'd0, running}, 32'd1);
    send(mk(4'b1000, 16'h0, 1'b0, 1'b0, 16'hAAAA, 1'b0), 16);
    check("running_fell", {31'd0, running}, 32'd0);

    // Slot errors
    base_fs = fs_count;
    send(mk(4'b1001, 16'h4321, 1'b1, 1'b1, 16'hFE6B, 1'b0), 16);
    check("multi_flag_error", {31'd0, slot_error}, 32'd1);
    check("multi_flag_fs", fs_count - base_fs, 32'd1);
    send(mk(4'b0000, 16'h0, 1'b0, 1'b1, 16'hAAAA, 1'b0), 16);
    send(mk(4'b0100, 16'h0, 1'b0, 1'b1, 16'h2840, 1'b0), 16);
    check("error_sticky", {31'd0, slot_error}, 32'd1);

    // Reset mid-word
    send(mk(4'b0001, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b1), 8);
    reset_n = 1'b0;
    #1;
    check("midreset_serial", {31'd0, serial_out}, 32'd0);
    check("midreset_running", {31'd0, running}, 32'd0);
    check("midreset_error", {31'd0, slot_error}, 32'd0);
    check("midreset_underrun", {16'd0, underrun_ct}, 32'd0);
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
    send(mk(4'b0001, 16'h7777, 1'b1, 1'b1, 16'hAAAA, 1'b0), 16);

    // Short spacing, then interval longer than a word
    send(mk(4'b1000, 16'h0, 1'b0, 1'b1, 16'hFE6B, 1'b0), 10);
    send(mk(4'b0100, 16'h0, 1'b0, 1'b1, 16'h2840, 1'b0), 16);
    send(mk(4'b0001, 16'h5678, 1'b1, 1'b1, 16'h5678, 1'b1), 20);
    send(mk(4'b0010, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b0), 16);
    check("running_end", {31'd0, running}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_word_scheduler.md
# frame_word_scheduler

Sequences the 16-bit telemetry word datapath: at every word boundary it selects the next word source (frame sync 1, frame sync 2, subframe ID, payload data, or fill) and serialises it MSB-first. Sits downstream of the frame enable/slot generator and upstream of the line driver. It drains a first-word-fall-through payload FIFO and maintains the subframe counter.

## Interface
- SYNC1, 16'hFE6B, word emitted in frame sync 1 slot
- SYNC2, 16'h2840, word emitted in frame sync 2 slot
- FILL_WORD, 16'hAAAA, word emitted when no payload is available, on slot errors, or while idle
- clock_in  input  1  single clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  run request
- word_strobe  input  1  one-cycle pulse at each word boundary
- slot_f1, slot_f2, slot_sf, slot_d  input  1 each  slot type of the word loaded on the strobe cycle
- sf_max  input  16  subframe counter terminal value
- data_in  input  16  FIFO head word (FWFT)
- data_valid  input  1  FIFO not empty
- data_ready  output  1  FIFO pop
- serial_out  output  1  serial bitstream
- frame_start  output  1  pulse at each emitted SYNC1
- running  output  1  state == RUN
- slot_error  output  1  sticky slot-flag error
- underrun_ct  output  16  saturating payload underrun count

## Operation
- States: IDLE, RUN. Reset to IDLE.
- IDLE -> RUN: on a cycle with word_strobe & slot_f1 & enable. That word is SYNC1.
- RUN -> IDLE: on a cycle with word_strobe & slot_f1 & !enable. That word is FILL_WORD. Frames are never truncated.
- Source selection on a strobe in RUN, with priority f1 > f2 > sf > d:
  - f1: SYNC1.
  - f2: SYNC2.
  - sf: sf_count.
  - d: data_in if data_valid, else FILL_WORD and underrun_ct += 1 (saturates at 16'hFFFF).
  - No flag set: FILL_WORD and slot_error set.
- More than one flag set on a strobe (any state): highest-priority flag wins and slot_error is set. slot_error clears only on reset.
- In IDLE every strobe loads FILL_WORD. No FIFO pops, no counter updates.
- data_ready = word_strobe & slot_d & highest-priority flag is d & data_valid & state==RUN (combinational). Exactly one pop per consumed word.
- sf_count (16-bit internal): reset 0.
  - Updates only on f1 strobes that stay in RUN, excluding the IDLE -> RUN strobe: if sf_count >= sf_max then 0, else +1.
  - The first frame after entering RUN uses sf_count = 0.
  - sf_max = 0 holds the count at 0.
  - Leaving RUN does not reset sf_count.
- frame_start: registered one-cycle pulse, the cycle after each strobe that loads SYNC1.

## Timing
- Reset values: serial_out 0, data_ready 0, frame_start 0, running 0, slot_error 0, underrun_ct 0, shift register 0, sf_count 0.
- Strobe on cycle T: the shift register loads at edge T. serial_out = bit 15 from that edge, then bits 14..0 on the next 15 edges (shift left, zero fill).
- Latency: first bit appears one clock after the strobe edge. serial_out is registered.
- Strobe arrives before 16 bits are shifted: reload immediately and drop the remainder.
- Strobe interval > 16: zeros follow bit 0.
- underrun_ct, slot_error, running and sf_count update on the strobe edge. running reflects the new state one cycle after the strobe.
- enable changes mid-frame: no effect until the next f1 strobe.
- reset_n asserted mid-word: all state is cleared immediately. After release, stay IDLE until the next qualifying f1 strobe.

## Test plan
- Run/serialise: enable=1, 16-clock strobes, frame f1,f2,d,d,sf with FIFO words 1234,5678 and sf_max=3. Required serial stream: FE6B, 2840, 1234, 5678, 0000. frame_start pulses once; data_ready pulses twice.
- SF wrap: sf_max=2, five frames. SF words must be 0,1,2,0,1.
- Underrun: data_valid=0 on a d slot. Required: AAAA emitted, data_ready stays 0, underrun_ct 0 -> 1. Preload 16'hFFFE, force three underruns: count must saturate at FFFF.
- Enable handling: enable=0 at reset gives all AAAA. Raise enable mid-frame: no change until the next f1. Drop enable mid-frame: the frame completes, the next f1 slot emits AAAA, and running falls.
- Slot errors: f1 & d together emit FE6B and set slot_error with no pop. A strobe with no flags emits AAAA. slot_error stays 1 until reset.
- Reset mid-word and short strobe spacing: reset_n low at bit 7 gives serial_out 0 immediately and IDLE. A strobe after 10 clocks reloads with no leftover bits.
